// File: rtl/ls_agu_arbiter_pkg.sv
// Shared types for the load/store AGU arbiter: output packet, round-robin pointer and FSM state.
// The misalignment helper is only referenced when LS_MISALIGN_CHECK_EN is defined.
package ls_agu_arbiter_pkg;

    localparam int LS_ROB_IDX_W = 5;

    typedef enum logic {
        LS_RR_LOAD  = 1'b0,
        LS_RR_STORE = 1'b1
    } ls_rr_e;

    typedef enum logic {
        AGU_EMPTY = 1'b0,
        AGU_FULL  = 1'b1
    } agu_state_e;

    typedef struct packed {
        logic [31:0]             addr;
        logic [LS_ROB_IDX_W-1:0] rob_id;
        logic                    is_store;
        logic [2:0]              funct3;
        logic                    misaligned;
    } ls_agu_pkt_t;

    // funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic ls_misaligned(input logic [2:0] funct3, input logic [31:0] addr);
        return ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/ls_agu_arbiter_rr_arb2.sv
// Two-requester round-robin grant (load vs store); the priority pointer lives here and
// only moves on a contested grant.
import ls_agu_arbiter_pkg::*;

module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_ld,
    input  logic i_req_st,
    output logic o_gnt_ld,
    output logic o_gnt_st
);

    ls_rr_e r_ptr;
    logic   w_both;

    assign w_both   = i_req_ld & i_req_st;
    assign o_gnt_ld = i_en & i_req_ld & (~i_req_st | (r_ptr == LS_RR_LOAD));
    assign o_gnt_st = i_en & i_req_st & (~i_req_ld | (r_ptr == LS_RR_STORE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= LS_RR_LOAD;
        end else if (i_en && w_both) begin
            r_ptr <= (r_ptr == LS_RR_LOAD) ? LS_RR_STORE : LS_RR_LOAD;
        end
    end

endmodule

// File: rtl/ls_agu_arbiter.sv
// Shared load/store AGU: round-robin pick, rs1+imm adder and a one-entry pass-through
// output slot toward the LSQ. Optional misalignment flag under LS_MISALIGN_CHECK_EN.
//
// state     | meaning
// AGU_EMPTY | output slot empty, lsq_addr_valid=0
// AGU_FULL  | output slot holds an address, lsq_addr_valid=1
import ls_agu_arbiter_pkg::*;

module ls_agu_arbiter #(
    parameter int ROB_IDX_W = LS_ROB_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ld_req_valid,
    output logic                 ld_req_ready,
    input  logic [31:0]          ld_rs1_data,
    input  logic [31:0]          ld_imm_data,
    input  logic [ROB_IDX_W-1:0] ld_rob_id,
    input  logic [2:0]           ld_funct3,
    input  logic                 st_req_valid,
    output logic                 st_req_ready,
    input  logic [31:0]          st_rs1_data,
    input  logic [31:0]          st_imm_data,
    input  logic [ROB_IDX_W-1:0] st_rob_id,
    input  logic [2:0]           st_funct3,
    output logic                 lsq_addr_valid,
    input  logic                 lsq_addr_ready,
    output logic [31:0]          lsq_addr,
    output logic [ROB_IDX_W-1:0] lsq_rob_id,
    output logic                 lsq_is_store,
    output logic [2:0]           lsq_funct3,
    output logic                 lsq_misaligned
);

    agu_state_e  r_state;
    logic        r_valid;
    ls_agu_pkt_t r_pkt;

    logic        w_can_accept;
    logic        w_gnt_ld;
    logic        w_gnt_st;
    logic        w_grant;
    logic [31:0] w_sum;
    ls_agu_pkt_t w_pkt;

    // Slot may drain and refill in the same cycle.
    assign w_can_accept = ~flush & ((r_state == AGU_EMPTY) | lsq_addr_ready);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_can_accept),
        .i_req_ld (ld_req_valid),
        .i_req_st (st_req_valid),
        .o_gnt_ld (w_gnt_ld),
        .o_gnt_st (w_gnt_st)
    );

    assign w_grant      = w_gnt_ld | w_gnt_st;
    assign ld_req_ready = w_gnt_ld;
    assign st_req_ready = w_gnt_st;

    // Single shared adder; operands muxed by the grant, carry-out dropped.
    assign w_sum = w_gnt_st ? (st_rs1_data + st_imm_data) : (ld_rs1_data + ld_imm_data);

    always_comb begin
        w_pkt          = '0;
        w_pkt.addr     = w_sum;
        w_pkt.rob_id   = w_gnt_st ? st_rob_id : ld_rob_id;
        w_pkt.is_store = w_gnt_st;
        w_pkt.funct3   = w_gnt_st ? st_funct3 : ld_funct3;
`ifdef LS_MISALIGN_CHECK_EN
        w_pkt.misaligned = ls_misaligned(w_pkt.funct3, w_sum);
`else
        w_pkt.misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= AGU_EMPTY;
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (flush) begin
            r_state <= AGU_EMPTY;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                AGU_EMPTY: begin
                    if (w_grant) begin
                        r_state <= AGU_FULL;
                        r_valid <= 1'b1;
                        r_pkt   <= w_pkt;
                    end
                end
                AGU_FULL: begin
                    if (w_grant) begin
                        r_pkt <= w_pkt;
                    end else if (lsq_addr_ready) begin
                        r_state <= AGU_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= AGU_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign lsq_addr_valid = r_valid;
    assign lsq_addr       = r_pkt.addr;
    assign lsq_rob_id     = r_pkt.rob_id;
    assign lsq_is_store   = r_pkt.is_store;
    assign lsq_funct3     = r_pkt.funct3;
`ifdef LS_MISALIGN_CHECK_EN
    assign lsq_misaligned = r_pkt.misaligned;
`else
    assign lsq_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_ls_agu_arbiter.sv
// Directed, table-driven bench for ls_agu_arbiter; misalignment expectations follow
// whether LS_MISALIGN_CHECK_EN is defined for the build.
module tb_ls_agu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_req_valid, st_req_valid;
    logic        ld_req_ready, st_req_ready;
    logic [31:0] ld_rs1_data, ld_imm_data, st_rs1_data, st_imm_data;
    logic [4:0]  ld_rob_id, st_rob_id;
    logic [2:0]  ld_funct3, st_funct3;
    logic        lsq_addr_valid, lsq_addr_ready;
    logic [31:0] lsq_addr;
    logic [4:0]  lsq_rob_id;
    logic        lsq_is_store;
    logic [2:0]  lsq_funct3;
    logic        lsq_misaligned;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ls_agu_arbiter #(.ROB_IDX_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .ld_req_valid   (ld_req_valid),
        .ld_req_ready   (ld_req_ready),
        .ld_rs1_data    (ld_rs1_data),
        .ld_imm_data    (ld_imm_data),
        .ld_rob_id      (ld_rob_id),
        .ld_funct3      (ld_funct3),
        .st_req_valid   (st_req_valid),
        .st_req_ready   (st_req_ready),
        .st_rs1_data    (st_rs1_data),
        .st_imm_data    (st_imm_data),
        .st_rob_id      (st_rob_id),
        .st_funct3      (st_funct3),
        .lsq_addr_valid (lsq_addr_valid),
        .lsq_addr_ready (lsq_addr_ready),
        .lsq_addr       (lsq_addr),
        .lsq_rob_id     (lsq_rob_id),
        .lsq_is_store   (lsq_is_store),
        .lsq_funct3     (lsq_funct3),
        .lsq_misaligned (lsq_misaligned)
    );

    typedef struct {
        logic        fl;
        logic        ldv;
        logic [31:0] lrs, limm;
        logic [4:0]  lrob;
        logic [2:0]  lf3;
        logic        stv;
        logic [31:0] srs, simm;
        logic [4:0]  srob;
        logic [2:0]  sf3;
        logic        rdy;
        logic        e_ldr, e_str, e_vld;
        logic [31:0] e_addr;
        logic [4:0]  e_rob;
        logic        e_st;
        logic [2:0]  e_f3;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic fl, input logic ldv, input logic [31:0] lrs, input logic [31:0] limm,
        input logic [4:0] lrob, input logic [2:0] lf3,
        input logic stv, input logic [31:0] srs, input logic [31:0] simm,
        input logic [4:0] srob, input logic [2:0] sf3, input logic rdy,
        input logic e_ldr, input logic e_str, input logic e_vld, input logic [31:0] e_addr,
        input logic [4:0] e_rob, input logic e_st, input logic [2:0] e_f3, input logic e_mis);
        vec_t v;
        v.fl = fl; v.ldv = ldv; v.lrs = lrs; v.limm = limm; v.lrob = lrob; v.lf3 = lf3;
        v.stv = stv; v.srs = srs; v.simm = simm; v.srob = srob; v.sf3 = sf3; v.rdy = rdy;
        v.e_ldr = e_ldr; v.e_str = e_str; v.e_vld = e_vld; v.e_addr = e_addr;
        v.e_rob = e_rob; v.e_st = e_st; v.e_f3 = e_f3; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        flush          = v.fl;
        ld_req_valid   = v.ldv;  ld_rs1_data = v.lrs; ld_imm_data = v.limm;
        ld_rob_id      = v.lrob; ld_funct3   = v.lf3;
        st_req_valid   = v.stv;  st_rs1_data = v.srs; st_imm_data = v.simm;
        st_rob_id      = v.srob; st_funct3   = v.sf3;
        lsq_addr_ready = v.rdy;
    endtask

    function automatic logic exp_mis(input logic m);
`ifdef LS_MISALIGN_CHECK_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0,0);
        // single load, both-valid round robin, backpressure, wrap, flush, misalign cases
        vecs.push_back(mk(0,1,32'h1000_0000,32'h4,3,2, 0,0,0,0,0, 1, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1,32'h1000_0004,3,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100,32'h10,1,0, 1,32'h200,32'h20,2,2, 1, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h300,32'h1,4,4, 1,32'h200,32'h20,2,2, 1, 0,1,1,32'h110,1,0,0,0));
        vecs.push_back(mk(0,1,32'h300,32'h1,4,4, 1,32'h400,32'h3,5,1, 1, 1,0,1,32'h220,2,1,2,0));
        vecs.push_back(mk(0,1,32'h500,32'h2,6,2, 1,32'h400,32'h3,5,1, 1, 0,1,1,32'h301,4,0,4,0));
        vecs.push_back(mk(0,1,32'h500,32'h2,6,2, 0,0,0,0,0, 1, 1,0,1,32'h403,5,1,1,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,0, 1,32'h600,32'h4,7,0, 0, 0,0,1,32'h502,6,0,2,1));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h600,32'h4,7,0, 1, 0,1,1,32'h502,6,0,2,1));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,1,32'h604,7,1,0,0));
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,32'h8,8,2, 0,0,0,0,0, 1, 1,0,1,32'h604,7,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10,32'hFFFF_FFF0,9,2, 1, 0,1,1,32'h4,8,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,1,32'h0,9,1,2,0));
        vecs.push_back(mk(1,1,0,0,10,2, 1,0,0,11,0, 1, 0,0,1,32'h0,9,1,2,0));
        vecs.push_back(mk(0,1,32'h700,32'h2,10,1, 1,32'h800,32'h3,11,0, 0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h800,32'h3,11,0, 0, 0,0,1,32'h702,10,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h800,32'h3,11,0, 1, 0,1,1,32'h702,10,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,1,32'h803,11,1,0,0));

        rst = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        chk("reset_valid", {31'd0, lsq_addr_valid}, 32'd0);
        chk("reset_addr", lsq_addr, 32'd0);
        chk("reset_rob", {27'd0, lsq_rob_id}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_ld_ready", i), {31'd0, ld_req_ready}, {31'd0, vecs[i].e_ldr});
            chk($sformatf("v%0d_st_ready", i), {31'd0, st_req_ready}, {31'd0, vecs[i].e_str});
            chk($sformatf("v%0d_valid", i), {31'd0, lsq_addr_valid}, {31'd0, vecs[i].e_vld});
            if (vecs[i].e_vld) begin
                chk($sformatf("v%0d_addr", i), lsq_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_rob", i), {27'd0, lsq_rob_id}, {27'd0, vecs[i].e_rob});
                chk($sformatf("v%0d_is_store", i), {31'd0, lsq_is_store}, {31'd0, vecs[i].e_st});
                chk($sformatf("v%0d_funct3", i), {29'd0, lsq_funct3}, {29'd0, vecs[i].e_f3});
                chk($sformatf("v%0d_misaligned", i), {31'd0, lsq_misaligned},
                    {31'd0, exp_mis(vecs[i].e_mis)});
            end
        end

        // Async reset in the middle of a stall: outputs clear without a clock edge.
        @(posedge clk);
        #1;
        drive(idle);
        #2;
        chk("stall_valid", {31'd0, lsq_addr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, lsq_addr_valid}, 32'd0);
        chk("arst_addr", lsq_addr, 32'd0);
        chk("arst_rob", {27'd0, lsq_rob_id}, 32'd0);
        chk("arst_is_store", {31'd0, lsq_is_store}, 32'd0);
        chk("arst_funct3", {29'd0, lsq_funct3}, 32'd0);
        chk("arst_misaligned", {31'd0, lsq_misaligned}, 32'd0);

        // Pointer was STORE before reset; reset must bring it back to LOAD.
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(0,1,32'h40,32'h4,12,2, 1,32'h80,32'h8,13,2, 0, 0,0,0,0,0,0,0,0));
        @(negedge clk);
        chk("post_rst_ld_ready", {31'd0, ld_req_ready}, 32'd1);
        chk("post_rst_st_ready", {31'd0, st_req_ready}, 32'd0);
        @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        chk("post_rst_valid", {31'd0, lsq_addr_valid}, 32'd1);
        chk("post_rst_addr", lsq_addr, 32'h44);
        chk("post_rst_rob", {27'd0, lsq_rob_id}, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
